// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared IEEE-754 double field widths and result-flag layout
package fp_pkg;

  localparam int EXP_W = 11;
  localparam int MAN_W = 52;
  localparam int DBL_W = 64;
  localparam int FLAG_W = 4;

  localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;

  localparam int FLAG_SPECIAL = 3;
  localparam int FLAG_ZERO    = 2;
  localparam int FLAG_DENORM  = 1;
  localparam int FLAG_NEG     = 0;

endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - combinational double classifier: {special, zero, denorm, neg}
module fp_classify
  import fp_pkg::*;
(
  input  logic [DBL_W-1:0]  result,
  output logic [FLAG_W-1:0] flags
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign exp_f = result[DBL_W-2 -: EXP_W];
  assign man_f = result[MAN_W-1:0];

  // Any all-ones exponent counts as special; the adder never emits a finite value there.
  always_comb begin
    flags               = '0;
    flags[FLAG_SPECIAL] = (exp_f == EXP_ALL_ONES);
    flags[FLAG_ZERO]    = (exp_f == '0) && (man_f == '0);
    flags[FLAG_DENORM]  = (exp_f == '0) && (man_f != '0);
    flags[FLAG_NEG]     = result[DBL_W-1];
  end

endmodule

// File: rtl/fp_add_wb_queue.sv
// rtl/fp_add_wb_queue.sv - in-order result queue between the FP adder and the register-file write port
module fp_add_wb_queue
  import fp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DBL_W-1:0]           in_result,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [DBL_W-1:0]           wb_data,
  output logic [TAG_W-1:0]           wb_tag,
  output logic [FLAG_W-1:0]          wb_flags,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       sticky_special
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DBL_W-1:0]  mem_data  [DEPTH];
  logic [TAG_W-1:0]  mem_tag   [DEPTH];
  logic [FLAG_W-1:0] mem_flags [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sticky_q, sticky_d;

  logic [FLAG_W-1:0] in_flags;
  logic              push, pop, push_en;

  fp_classify u_classify (
    .result (in_result),
    .flags  (in_flags)
  );

  // Gating on rst keeps the producer stalled while the queue is held in reset.
  assign in_ready = !rst && (count_q < CNT_W'(DEPTH));
  assign wb_valid = (count_q != '0);
  assign push     = in_valid && in_ready;
  assign pop      = wb_valid && wb_ready;
  assign push_en  = push && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sticky_d = sticky_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      sticky_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (in_flags[FLAG_SPECIAL]) sticky_d = 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  // Storage is deliberately unreset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_data[wr_ptr_q]  <= in_result;
      mem_tag[wr_ptr_q]   <= in_tag;
      mem_flags[wr_ptr_q] <= in_flags;
    end
  end

  assign wb_data        = wb_valid ? mem_data[rd_ptr_q]  : '0;
  assign wb_tag         = wb_valid ? mem_tag[rd_ptr_q]   : '0;
  assign wb_flags       = wb_valid ? mem_flags[rd_ptr_q] : '0;
  assign count          = count_q;
  assign sticky_special = sticky_q;

endmodule

// File: doc/fp_add_wb_queue.md
Name: fp_add_wb_queue

Overview:
- Downstream stage of the double-precision FP adder in the VLIW FP execution lane.
- Captures each 64-bit adder result together with its destination register tag and classifies the result (special, zero, denormal, sign).
- Buffers results in a small in-order FIFO and presents them to the FP register-file write port with a valid/ready handshake.
- Decouples the combinational adder from write-port stalls caused by other VLIW slots.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- TAG_W, 5, width of the destination register tag.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of queue contents and sticky status.
- in_valid  input  1  adder result present this cycle.
- in_ready  output  1  queue can accept a result.
- in_result  input  64  IEEE-754 double from the adder: sign [63], exponent [62:52], mantissa [51:0].
- in_tag  input  TAG_W  destination FP register index.
- wb_valid  output  1  head entry valid for writeback.
- wb_ready  input  1  register-file write port grants writeback this cycle.
- wb_data  output  64  head result.
- wb_tag  output  TAG_W  head destination tag.
- wb_flags  output  4  head flags {special, zero, denorm, neg}.
- count  output  $clog2(DEPTH+1)  current occupancy.
- sticky_special  output  1  set once any special result has been enqueued since reset or flush.

Behaviour:
- Reset (async, rst=1): read/write pointers 0, count 0, wb_valid 0, sticky_special 0. The storage array is not reset. in_ready=1 once rst deasserts.
- Push: in_valid && in_ready at a rising edge. Writes result, tag and flags to mem[wr_ptr]; wr_ptr increments mod DEPTH.
- Pop: wb_valid && wb_ready at a rising edge. rd_ptr increments mod DEPTH.
- in_ready = (count < DEPTH). There is no same-cycle pass-through when full: with the queue full and a pop pending, in_ready stays 0 that cycle.
- wb_valid = (count != 0).
- Latency: a result pushed at edge N is visible on wb_* after edge N. There is no combinational path from in_* to wb_*.
- Simultaneous push and pop (neither full nor empty): both pointers advance, count unchanged.
- Push while empty: count 0 -> 1. Pop while empty cannot occur, since wb_valid=0.
- When wb_valid=0, wb_data, wb_tag and wb_flags are forced to 0.
- Flags are computed from in_result at enqueue and stored with the entry (exp=in_result[62:52], man=in_result[51:0]):
  - special = &exp (covers inf/NaN; the adder emits all-ones for any infinite operand).
  - zero = (exp==0) && (man==0).
  - denorm = (exp==0) && (man!=0).
  - neg = in_result[63]. Negative zero keeps neg=1.
- sticky_special sets on any push with special=1 and holds until flush or rst.
- Flush: at the edge where flush=1, pointers, count and sticky_special clear to 0. A coincident push or pop is discarded. Flush has priority over push, pop and the sticky set.
- Reset mid-operation: all entries are lost immediately (async). Outputs reach their reset values without waiting for a clock edge.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty is derived from count, not from pointer equality.

Decomposition:
- Shared package fp_pkg holds:
  - EXP_W=11, MAN_W=52, DBL_W=64.
  - EXP_ALL_ONES constant.
  - Flag bit-index constants: FLAG_SPECIAL=3, FLAG_ZERO=2, FLAG_DENORM=1, FLAG_NEG=0.
- One sub-module, fp_classify: purely combinational, 64-bit input to 4-bit flags. It is reused later by the multiply-lane writeback.
- The FIFO storage and control stay inline.

Test Plan:
- Reset, then push 0x402C000000000000 with tag 3. Next cycle: wb_valid=1, wb_data=0x402C000000000000, wb_tag=3, wb_flags=4'b0000, count=1.
- Hold wb_ready=0 and push 4 results (tags 1-4). Required: count=4, in_ready=0. A 5th in_valid is ignored. Then wb_ready=1 for 4 cycles: tags pop in order 1,2,3,4, count returns to 0, wb_* return to 0.
- Push 0x7FFFFFFFFFFFFFFF, then 0x8000000000000000, then 0x0000000000000001. Required flags: 4'b1000, 4'b0101, 4'b0010. sticky_special=1 from the cycle after the first push.
- With count=2, assert in_valid and wb_ready together for 3 cycles. Required: count stays 2 and output order is preserved across pointer wrap.
- With count=3 and sticky_special=1, assert flush together with in_valid. Next cycle: count=0, wb_valid=0, sticky_special=0, and the pushed entry is absent.
- With count=2, assert rst asynchronously between clock edges. Required: wb_valid=0, count=0, in_ready=0 during reset, and in_ready=1 after release.
